// File: rtl/ddr_csr_bank_dbuf.sv
// Generic DDR CSR bank: shadow/active config words, sticky W1C status,
// registered read response and frequency-switch commit handshake.
module ddr_csr_bank_dbuf #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int NUM_CFG = 4,
  parameter int NUM_STA = 2,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_CFG*DWIDTH-1:0] CFG_POR = '0,
  parameter logic [NUM_CFG*DWIDTH-1:0] CFG_MSK = '1,
  parameter logic [NUM_STA*DWIDTH-1:0] STA_STICKY = '0
) (
  input  logic                      i_hclk,
  input  logic                      i_hreset,
  input  logic                      i_write,
  input  logic                      i_read,
  input  logic [AWIDTH-1:0]         i_addr,
  input  logic [DWIDTH-1:0]         i_wdata,
  input  logic [DWIDTH/8-1:0]       i_wstrb,
  output logic                      o_ready,
  output logic                      o_rvalid,
  output logic [DWIDTH-1:0]         o_rdata,
  output logic                      o_error,
  output logic [NUM_CFG*DWIDTH-1:0] o_cfg,
  input  logic [NUM_STA*DWIDTH-1:0] i_sta,
  input  logic                      i_update,
  output logic                      o_update_ack,
  output logic                      o_pending
);

  localparam int SW   = DWIDTH / 8;
  localparam int IW   = AWIDTH - 2;
  localparam int CTRL = NUM_CFG + NUM_STA;
  localparam int NREG = CTRL + 1;
  localparam logic [NUM_CFG*DWIDTH-1:0] CFG_RST = CFG_POR & CFG_MSK;

  logic [NUM_CFG*DWIDTH-1:0] shd_q, shd_d, act_q, act_d;
  logic [NUM_STA*DWIDTH-1:0] sta_q, sta_d;
  logic                      auto_q, auto_d;
  logic                      pend_q, pend_d;
  logic                      rvalid_q, err_q, ack_q;
  logic [DWIDTH-1:0]         rdata_q, rdata_d;

  logic [DWIDTH-1:0] bm, w, clr;
  logic [IW-1:0]     idx;
  logic              req, bad, wr_ok, rd_ok, ctl_wr, commit;

  assign o_ready      = ~ack_q;
  assign o_rvalid     = rvalid_q;
  assign o_rdata      = rdata_q;
  assign o_error      = err_q;
  assign o_cfg        = act_q;
  assign o_update_ack = ack_q;
  assign o_pending    = pend_q;

  // BASE_ADDR is word aligned, so only the word index needs rebasing
  assign idx = i_addr[AWIDTH-1:2] - BASE_ADDR[AWIDTH-1:2];

  always_comb begin
    bm = '0;
    for (int b = 0; b < SW; b++) bm[b*8 +: 8] = {8{i_wstrb[b]}};
  end

  assign req   = o_ready & (i_read | i_write);
  assign bad   = (i_read & i_write) | (i_addr[1:0] != 2'b00)
               | (idx >= IW'(NREG)) | (i_write & (i_wstrb == '0));
  assign wr_ok = req & i_write & ~bad;
  assign rd_ok = req & i_read & ~bad;

  assign ctl_wr = wr_ok & (idx == IW'(CTRL)) & i_wstrb[0];
  // Auto 0->1 with a pending shadow counts as a commit request
  assign commit = pend_q & (i_update |
                  (ctl_wr & (i_wdata[2] | (i_wdata[0] & ~auto_q))));

  always_comb begin
    rdata_d = '0;
    if (rd_ok) begin
      for (int k = 0; k < NUM_CFG; k++)
        if (idx == IW'(k)) rdata_d = shd_q[k*DWIDTH +: DWIDTH];
      for (int j = 0; j < NUM_STA; j++)
        if (idx == IW'(NUM_CFG + j)) rdata_d = sta_q[j*DWIDTH +: DWIDTH];
      if (idx == IW'(CTRL)) rdata_d = DWIDTH'({pend_q, auto_q});
    end
  end

  always_comb begin
    shd_d  = shd_q;
    act_d  = commit ? shd_q : act_q;
    pend_d = commit ? 1'b0 : pend_q;
    auto_d = ctl_wr ? i_wdata[0] : auto_q;
    w      = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (wr_ok && idx == IW'(k)) begin
        w = ((shd_q[k*DWIDTH +: DWIDTH] & ~bm) | (i_wdata & bm))
          & CFG_MSK[k*DWIDTH +: DWIDTH];
        shd_d[k*DWIDTH +: DWIDTH] = w;
        if (auto_q) act_d[k*DWIDTH +: DWIDTH] = w;
        else        pend_d = 1'b1;
      end
    end
  end

  // Set wins over clear because i_sta is ORed in after the clear
  always_comb begin
    sta_d = '0;
    clr   = '0;
    for (int j = 0; j < NUM_STA; j++) begin
      clr = '0;
      if (wr_ok && idx == IW'(NUM_CFG + j))
        clr = i_wdata & bm & STA_STICKY[j*DWIDTH +: DWIDTH];
      sta_d[j*DWIDTH +: DWIDTH] =
        (sta_q[j*DWIDTH +: DWIDTH] & STA_STICKY[j*DWIDTH +: DWIDTH] & ~clr)
        | i_sta[j*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      shd_q    <= CFG_RST;
      act_q    <= CFG_RST;
      sta_q    <= '0;
      auto_q   <= 1'b1;
      pend_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      shd_q    <= shd_d;
      act_q    <= act_d;
      sta_q    <= sta_d;
      auto_q   <= auto_d;
      pend_q   <= pend_d;
      rvalid_q <= req;
      err_q    <= req & bad;
      rdata_q  <= rdata_d;
      ack_q    <= commit;
    end
  end

endmodule

// File: tb/tb_ddr_csr_bank_dbuf.sv
// Directed bench for ddr_csr_bank_dbuf; responses are checked by a
// scoreboard queue, side outputs by direct comparisons.
module tb_ddr_csr_bank_dbuf;

  localparam logic [31:0]  BASE = 32'h100;
  localparam logic [127:0] POR  = {32'h0, 32'h0, 32'h0000_00A5, 32'h0};
  localparam logic [127:0] MSK  = {32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h0000_FFFF, 32'hFFFF_FFFF};
  localparam logic [63:0]  STK  = {32'h0, 32'h1};
  localparam logic [127:0] RST  = {32'h0, 32'h0, 32'h0000_00A5, 32'h0};

  logic         clk = 0;
  logic         rst = 1;
  logic         i_write = 0, i_read = 0;
  logic [31:0]  i_addr = 0, i_wdata = 0;
  logic [3:0]   i_wstrb = 0;
  logic         o_ready, o_rvalid, o_error, o_update_ack, o_pending;
  logic [31:0]  o_rdata;
  logic [127:0] o_cfg;
  logic [63:0]  i_sta = 0;
  logic         i_update = 0;

  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] expq[$];

  ddr_csr_bank_dbuf #(
    .AWIDTH(32), .DWIDTH(32), .NUM_CFG(4), .NUM_STA(2),
    .BASE_ADDR(BASE), .CFG_POR(POR), .CFG_MSK(MSK), .STA_STICKY(STK)
  ) dut (
    .i_hclk(clk), .i_hreset(rst),
    .i_write(i_write), .i_read(i_read), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_error(o_error), .o_cfg(o_cfg), .i_sta(i_sta),
    .i_update(i_update), .o_update_ack(o_update_ack),
    .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_rvalid) begin
      logic [32:0] e;
      n_chk++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got err=%0b data=%0h want none",
                 o_error, o_rdata);
      end else begin
        e = expq.pop_front();
        if ({o_error, o_rdata} !== e) begin
          n_fail++;
          $display("FAIL resp: got err=%0b data=%0h want err=%0b data=%0h",
                   o_error, o_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic acc(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
    i_read = rd; i_write = wr; i_addr = a; i_wdata = d; i_wstrb = s;
    expq.push_back({ee, er});
    @(negedge clk);
    i_read = 0; i_write = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er);
    acc(1'b1, 1'b0, a, 32'h0, 4'h0, er, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    acc(1'b0, 1'b1, a, d, s, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_ack", o_update_ack, 0);
    chk("rst_cfg", o_cfg, RST);

    rd(BASE + 4, 32'h0000_00A5);
    wr(BASE + 4, 32'h1234_5678, 4'b0001);
    chk("auto_cfg1", o_cfg[63:32], 32'h78);
    chk("auto_pend", o_pending, 0);
    rd(BASE + 4, 32'h78);

    wr(BASE + 32'h18, 32'h0, 4'h1);
    rd(BASE + 32'h18, 32'h0);
    wr(BASE + 0, 32'hFF, 4'hF);
    chk("man_cfg0_hold", o_cfg[31:0], 32'h0);
    chk("man_pend", o_pending, 1);
    rd(BASE + 0, 32'hFF);
    rd(BASE + 32'h18, 32'h2);
    @(negedge clk);
    i_update = 1;
    @(negedge clk);
    i_update = 0;
    chk("upd_cfg0", o_cfg[31:0], 32'hFF);
    chk("upd_ack", o_update_ack, 1);
    chk("upd_ready", o_ready, 0);
    chk("upd_pend", o_pending, 0);
    @(negedge clk);
    chk("upd_ack_drop", o_update_ack, 0);
    chk("upd_ready_back", o_ready, 1);

    i_sta[0] = 1;
    @(negedge clk);
    i_sta[0] = 0;
    i_sta[63:32] = 32'hDEAD_0000;
    repeat (2) @(negedge clk);
    rd(BASE + 32'h10, 32'h1);
    rd(BASE + 32'h10, 32'h1);
    rd(BASE + 32'h14, 32'hDEAD_0000);
    i_sta[0] = 1;
    wr(BASE + 32'h10, 32'h1, 4'h1);
    i_sta[0] = 0;
    rd(BASE + 32'h10, 32'h1);
    wr(BASE + 32'h10, 32'h1, 4'h1);
    rd(BASE + 32'h10, 32'h0);
    wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'h14, 32'hDEAD_0000);

    acc(1'b1, 1'b0, BASE + 2, 32'h0, 4'h0, 32'h0, 1'b1);
    acc(1'b1, 1'b0, BASE + 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    acc(1'b1, 1'b1, BASE + 4, 32'hFFFF, 4'hF, 32'h0, 1'b1);
    acc(1'b0, 1'b1, BASE + 4, 32'hFFFF, 4'h0, 32'h0, 1'b1);
    acc(1'b0, 1'b1, 32'h0, 32'hFFFF, 4'hF, 32'h0, 1'b1);
    chk("err_cfg1", o_cfg[63:32], 32'h78);
    chk("err_pend", o_pending, 0);
    rd(BASE + 4, 32'h78);

    wr(BASE + 8, 32'hABCD, 4'hF);
    chk("tog_pend", o_pending, 1);
    wr(BASE + 32'h18, 32'h1, 4'h1);
    chk("tog_cfg2", o_cfg[95:64], 32'hABCD);
    chk("tog_ack", o_update_ack, 1);
    chk("tog_pend0", o_pending, 0);

    wr(BASE + 32'h18, 32'h0, 4'h1);
    wr(BASE + 32'hC, 32'h55, 4'hF);
    chk("cmt_hold", o_cfg[127:96], 32'h0);
    wr(BASE + 32'h18, 32'h4, 4'h1);
    chk("cmt_cfg3", o_cfg[127:96], 32'h55);
    chk("cmt_ack", o_update_ack, 1);
    rd(BASE + 32'h18, 32'h0);

    wr(BASE + 0, 32'h11, 4'hF);
    chk("rst2_pend_pre", o_pending, 1);
    @(negedge clk);
    i_read = 1; i_addr = BASE; i_update = 1; rst = 1;
    @(negedge clk);
    i_read = 0; i_update = 0;
    chk("rst2_rvalid", o_rvalid, 0);
    chk("rst2_pend", o_pending, 0);
    chk("rst2_cfg", o_cfg, RST);
    chk("rst2_ack", o_update_ack, 0);
    chk("rst2_ready", o_ready, 1);
    rst = 0;
    i_sta = 0;
    rd(BASE + 32'h18, 32'h1);
    rd(BASE + 0, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
